// File: rtl/if_fetch_queue.sv
// Fetch stage: PC redirect select, pipelined IM requests and an in-order fetch queue.
// Optional saturating perf counters are enabled with `define IF_FETCH_PERF_CNT_EN.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pc_src,
    input  logic [XLEN-1:0]  pc_imm,
    input  logic [XLEN-1:0]  pc_imm_rs1,
    output logic             im_req_valid,
    input  logic             im_req_ready,
    output logic [XLEN-1:0]  im_req_addr,
    input  logic             im_resp_valid,
    input  logic [31:0]      im_resp_data,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_instr,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);
    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q [FQ_DEPTH];
    logic [31:0]     instr_q [FQ_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [CW-1:0]   alloc_q, alloc_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            run_q;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            req_hs;
    logic            resp_drop;
    logic            resp_fill;
    logic            pop;
    logic [CW:0]     inflight;
    logic [PW-1:0]   tail_idx;
    logic [PW-1:0]   fill_idx;

    always_comb begin
        redirect = 1'b0;
        target   = fetch_pc_q;
        unique case (pc_src)
            2'b01: begin
                redirect = 1'b1;
                target   = pc_imm;
            end
            2'b10: begin
                redirect = 1'b1;
                target   = pc_imm_rs1;
            end
            default: begin
                redirect = 1'b0;
                target   = fetch_pc_q;
            end
        endcase
    end

    // Entries fill in order, so filled ones are exactly head..head+fill_q-1.
    assign inflight     = {1'b0, alloc_q} + {1'b0, drop_q};
    assign im_req_valid = run_q && (inflight < DEPTH_L);
    assign im_req_addr  = fetch_pc_q;
    assign req_hs       = im_req_valid && im_req_ready;
    assign resp_drop    = im_resp_valid && (drop_q != '0);
    assign resp_fill    = im_resp_valid && (drop_q == '0) && (fill_q < alloc_q);
    assign id_valid     = (fill_q != '0);
    assign pop          = id_valid && id_ready;
    assign tail_idx     = head_q + alloc_q[PW-1:0];
    assign fill_idx     = head_q + fill_q[PW-1:0];
    assign id_pc        = pc_q[head_q];
    assign id_instr     = instr_q[head_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = target;
            alloc_d    = '0;
            fill_d     = '0;
            drop_d     = drop_q + (alloc_q - fill_q) + CW'(req_hs)
                       - CW'(resp_drop || resp_fill);
        end else begin
            if (req_hs) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            head_d  = head_q + PW'(pop);
            alloc_d = alloc_q + CW'(req_hs) - CW'(pop);
            fill_d  = fill_q + CW'(resp_fill) - CW'(pop);
            drop_d  = drop_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            drop_q     <= '0;
            run_q      <= 1'b0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            drop_q     <= drop_d;
            run_q      <= 1'b1;
            if (req_hs && !redirect) begin
                pc_q[tail_idx] <= fetch_pc_q;
            end
            if (resp_fill) begin
                instr_q[fill_idx] <= im_resp_data;
            end
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W:0]   flush_sum;

    // Flushed work: every queue entry plus a request accepted in the redirect cycle.
    assign flush_sum = {1'b0, flush_q} + (CNT_W+1)'(alloc_q)
                     + (CNT_W+1)'(req_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (id_valid && !id_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redirect) begin
                flush_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
            end
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
